// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a framed byte stream, assembles
// little-endian words, writes them to imem and releases the core on a good checksum.
module imem_loader #(
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter int unsigned MAX_WORDS   = 64,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk_90,
  input  logic        rst_90,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wren_90,
  output logic [7:0]  addr,
  output logic [31:0] data_in_90,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [6:0]  words_loaded
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  csum_q, csum_d;
  logic [6:0]  len_q, len_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [5:0]  word_idx_q, word_idx_d;
  logic [31:0] word_q, word_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic        in_ready_q, in_ready_d;
  logic        wren_q, wren_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [6:0]  words_q, words_d;

  logic hs;
  logic tmo_hit;

  assign hs      = in_valid && in_ready_q;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    csum_d     = csum_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    word_d     = word_q;
    tmo_d      = tmo_q;
    addr_d     = addr_q;
    data_d     = data_q;
    words_d    = words_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          csum_d  = 8'h00;
          words_d = 7'd0;
          tmo_d   = '0;
        end
      end
      S_LEN: begin
        if (hs) begin
          csum_d = csum_q + in_data;
          len_d  = in_data[6:0];
          tmo_d  = '0;
          if (in_data > 8'(MAX_WORDS)) begin
            state_d = S_ERR;
          end else if (in_data == 8'h00) begin
            state_d = S_CSUM;
          end else begin
            state_d    = S_DATA;
            byte_idx_d = 2'd0;
            word_idx_d = 6'd0;
          end
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DATA: begin
        if (hs) begin
          csum_d = csum_q + in_data;
          tmo_d  = '0;
          word_d[{byte_idx_q, 3'b000} +: 8] = in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          // Latch the write beat so wren, addr and data line up in WRITE
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
            data_d  = word_d;
            addr_d  = BASE_ADDR + {word_idx_q, 2'b00};
            words_d = words_q + 7'd1;
          end
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 6'd1;
        state_d    = (7'(word_idx_q) == len_q - 7'd1) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (hs) begin
          tmo_d   = '0;
          state_d = (in_data == csum_q) ? S_DONE : S_ERR;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d   = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
    busy_d       = in_ready_d || (state_d == S_WRITE);
    wren_d       = (state_d == S_WRITE);
    done_d       = (state_d == S_DONE);
    err_d        = (state_d == S_ERR);
    core_rst_n_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_90) begin
    if (rst_90) begin
      state_q      <= S_IDLE;
      csum_q       <= 8'h00;
      len_q        <= 7'd0;
      byte_idx_q   <= 2'd0;
      word_idx_q   <= 6'd0;
      word_q       <= 32'h0;
      tmo_q        <= '0;
      in_ready_q   <= 1'b0;
      wren_q       <= 1'b0;
      addr_q       <= 8'h00;
      data_q       <= 32'h0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      words_q      <= 7'd0;
    end else begin
      state_q      <= state_d;
      csum_q       <= csum_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      word_q       <= word_d;
      tmo_q        <= tmo_d;
      in_ready_q   <= in_ready_d;
      wren_q       <= wren_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      words_q      <= words_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign wren_90      = wren_q;
  assign addr         = addr_q;
  assign data_in_90   = data_q;
  assign core_rst_n   = core_rst_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as frames are
// driven and checked against each wren pulse; end-of-load status checked per test.
module tb_imem_loader;

  localparam int unsigned TIMEOUT_CYC = 1024;
  localparam logic [7:0]  BASE        = 8'h00;

  logic        clk_90 = 1'b0;
  logic        rst_90;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wren_90;
  logic [7:0]  addr;
  logic [31:0] data_in_90;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;
  logic [6:0]  words_loaded;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] fw[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          wr_cnt = 0;
  int          wr_mark;

  imem_loader #(
    .BASE_ADDR   (BASE),
    .MAX_WORDS   (64),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_90       (clk_90),
    .rst_90       (rst_90),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .wren_90      (wren_90),
    .addr         (addr),
    .data_in_90   (data_in_90),
    .core_rst_n   (core_rst_n),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk_90 = ~clk_90;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every wren pulse must match the head of the scoreboard
  always @(negedge clk_90) begin
    if (wren_90 === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(addr), 32'(mon_e.a));
        chk("wr_data", data_in_90, mon_e.d);
      end
    end
  end

  task automatic do_start();
    @(negedge clk_90); start = 1'b1;
    @(negedge clk_90); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk_90);
    @(negedge clk_90);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clk_90);
      n++;
    end
    if (!in_ready) chk("hs_timeout", 32'(in_ready), 32'd1);
    @(posedge clk_90);
    #1 in_valid = 1'b0;
  endtask

  function automatic logic [7:0] calc_cs(input logic [7:0] n);
    logic [7:0] s;
    s = n;
    foreach (fw[i]) s = s + fw[i][7:0] + fw[i][15:8] + fw[i][23:16] + fw[i][31:24];
    return s;
  endfunction

  // Drives length, the words in fw (pushing expected writes) and a checksum byte
  task automatic send_frame(input logic [7:0] n, input logic [7:0] cs, input int gap);
    logic [31:0] w;
    send_byte(n, gap);
    for (int i = 0; i < fw.size(); i++) begin
      w = fw[i];
      exp_q.push_back({BASE + 8'(4 * i), w});
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    end
    send_byte(cs, gap);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk_90);
      n++;
    end
    if (busy) chk("busy_stuck", 32'(busy), 32'd0);
    @(negedge clk_90);
  endtask

  task automatic chk_end(input string tag, input logic ok, input int nw);
    chk({tag, "_done"}, 32'(done), 32'(ok));
    chk({tag, "_err"}, 32'(err), 32'(!ok));
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'(ok));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'(nw));
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, 32'({in_ready, wren_90, core_rst_n, busy, done, err}), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_data"}, data_in_90, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] cs;
    int         nw;
    rst_90 = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk_90);
    @(negedge clk_90);
    chk_all_zero("reset");
    rst_90 = 1'b0;

    // 1: two-word frame, good checksum
    do_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    fw = '{32'h00000821, 32'h10E00008};
    send_frame(8'h02, 8'h23, 0);
    wait_idle();
    chk_end("t1", 1'b1, 2);

    // 2: same frame, bad checksum
    do_start();
    chk("t2_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("t2_done_clr", 32'(done), 32'd0);
    send_frame(8'h02, 8'h24, 0);
    wait_idle();
    chk_end("t2", 1'b0, 2);

    // 3: over-length
    wr_mark = wr_cnt;
    do_start();
    send_byte(8'h41, 0);
    @(negedge clk_90);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    chk("t3_no_wr", 32'(wr_cnt - wr_mark), 32'd0);

    // 4: empty frame, then a restart re-asserts core reset
    wr_mark = wr_cnt;
    do_start();
    fw.delete();
    send_frame(8'h00, 8'h00, 0);
    wait_idle();
    chk_end("t4", 1'b1, 0);
    chk("t4_no_wr", 32'(wr_cnt - wr_mark), 32'd0);
    do_start();
    chk("t4_restart_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("t4_restart_busy", 32'(busy), 32'd1);

    // 5a: one word with 5-cycle valid gaps (continues the load started above)
    fw = '{32'hDEADBEEF};
    send_frame(8'h01, calc_cs(8'h01), 5);
    wait_idle();
    chk_end("t5a", 1'b1, 1);

    // 5b: timeout after a partial word
    wr_mark = wr_cnt;
    do_start();
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    repeat (TIMEOUT_CYC - 1) @(posedge clk_90);
    #1 chk("t5b_err_early", 32'(err), 32'd0);
    @(posedge clk_90);
    #1 chk("t5b_err", 32'(err), 32'd1);
    chk("t5b_busy", 32'(busy), 32'd0);
    chk("t5b_no_wr", 32'(wr_cnt - wr_mark), 32'd0);

    // 6a: reset during DATA
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(negedge clk_90); rst_90 = 1'b1;
    @(negedge clk_90);
    chk_all_zero("t6a");
    rst_90 = 1'b0;

    // 6b: start during a busy load is ignored
    do_start();
    fw = '{32'h0BADF00D};
    exp_q.push_back({BASE, fw[0]});
    cs = calc_cs(8'h01);
    send_byte(8'h01, 0);
    send_byte(8'h0D, 0);
    send_byte(8'hF0, 0);
    do_start();
    send_byte(8'hAD, 0);
    send_byte(8'h0B, 0);
    send_byte(cs, 0);
    wait_idle();
    chk_end("t6b", 1'b1, 1);

    // Boundary: maximum word count
    do_start();
    fw.delete();
    for (int i = 0; i < 64; i++) fw.push_back($urandom());
    send_frame(8'd64, calc_cs(8'd64), 0);
    wait_idle();
    chk_end("max64", 1'b1, 64);

    // A few random frames with random pacing
    for (int r = 0; r < 3; r++) begin
      nw = int'($urandom_range(1, 6));
      fw.delete();
      for (int i = 0; i < nw; i++) fw.push_back($urandom());
      do_start();
      send_frame(8'(nw), calc_cs(8'(nw)), int'($urandom_range(0, 3)));
      wait_idle();
      chk_end("rand", 1'b1, nw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
